lut32_8_loader: RTL

- Writer side of the team's 32 x 8 lookup-table interface: a register-array LUT that is loaded at run time by a byte stream, instead of being fixed at elaboration.
- A load command (base address, word count) starts a burst. Bytes arrive on a valid/ready handshake and are written at auto-incrementing addresses that wrap.
- A combinational read port, identical in timing to the fixed LUT read, serves consumers.
- Sits between the configuration/host stream and any logic that previously used a hard-coded table.

---
 rtl/lut_loader_pkg.sv | 11 +
 rtl/lut_ram32_8.sv | 18 +
 rtl/lut32_8_loader.sv | 85 ++++++++
 3 files changed

// File: rtl/lut_loader_pkg.sv
// lut_loader_pkg: shared sizes, types and FSM states for the run-time loaded 32x8 LUT
package lut_loader_pkg;
  localparam int WORDS  = 32;
  localparam int WIDTH  = 8;
  localparam int ADRS_W = 5;
  typedef logic [ADRS_W-1:0] lut_adrs_t;
  typedef logic [WIDTH-1:0]  lut_word_t;
  typedef logic [ADRS_W:0]   lut_count_t;
  localparam lut_count_t MAX_COUNT = lut_count_t'(WORDS);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;
endpackage

// File: rtl/lut_ram32_8.sv
// lut_ram32_8: register-array table with async clear, one sync write port, one combinational read port
module lut_ram32_8
  import lut_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADRS_W-1:0] wadrs,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADRS_W-1:0] radrs,
  output logic [WIDTH-1:0]  rdata
);
  lut_word_t mem [WORDS];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) mem <= '{default: '0};
    else if (we) mem[wadrs] <= wdata;
  assign rdata = mem[radrs];
endmodule

// File: rtl/lut32_8_loader.sv
// lut32_8_loader: byte-stream burst loader writing a 32x8 LUT at wrapping addresses, with combinational read
module lut32_8_loader
  import lut_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [ADRS_W-1:0] i_base_adrs,
  input  logic [ADRS_W:0]   i_count,
  input  logic              i_abort,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [WIDTH-1:0]  o_checksum,
  input  logic [ADRS_W-1:0] adrs,
  output logic [WIDTH-1:0]  dout
);
  loader_state_t state;
  lut_adrs_t     ptr;
  lut_count_t    remaining;
  logic          accept;
  logic          legal;
  assign accept = o_data_ready && i_data_valid;
  assign legal  = i_count != '0 && i_count <= MAX_COUNT;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      remaining    <= '0;
      o_checksum   <= '0;
      o_data_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          if (legal) begin
            state        <= LOAD;
            ptr          <= i_base_adrs;
            remaining    <= i_count;
            o_checksum   <= '0;
            o_data_ready <= 1'b1;
            o_busy       <= 1'b1;
          end else o_err <= 1'b1;
        end
        LOAD: begin
          if (accept) begin
            ptr        <= ptr + lut_adrs_t'(1);
            remaining  <= remaining - lut_count_t'(1);
            o_checksum <= o_checksum + i_data;
          end
          // abort wins over a simultaneous final byte: the byte lands but no done pulse
          if (i_abort) begin
            state        <= IDLE;
            o_data_ready <= 1'b0;
            o_busy       <= 1'b0;
          end else if (accept && remaining == lut_count_t'(1)) begin
            state        <= DONE;
            o_data_ready <= 1'b0;
            o_done       <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  lut_ram32_8 u_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (accept),
    .wadrs  (ptr),
    .wdata  (i_data),
    .radrs  (adrs),
    .rdata  (dout)
  );
endmodule
